// File: rtl/load_reply_unit_if.sv
// Issue-queue / load-pipeline bundle seen by one load_reply_unit.
interface load_reply_unit_if #(
  parameter int BANK_WIDTH = 4,
  parameter int ROB_WIDTH  = 6,
  parameter int MSHR_WIDTH = 2
);
  logic                  issue_en;
  logic [BANK_WIDTH-1:0] issue_idx;
  logic [ROB_WIDTH:0]    issue_rob_idx;
  logic                  issue_exception;
  logic                  s1_tlb_miss;
  logic                  s1_bank_conflict;
  logic                  s2_dcache_miss;
  logic [MSHR_WIDTH-1:0] s2_mshr_id;
  logic                  s2_mshr_full;
  logic                  s2_forward_fail;
  logic                  refill_en;
  logic [MSHR_WIDTH-1:0] refill_mshr_id;
  logic                  redirect;
  logic [ROB_WIDTH:0]    redirect_rob_idx;
  logic                  reply_fast_en;
  logic [1:0]            reply_fast_reason;
  logic [BANK_WIDTH-1:0] reply_fast_idx;
  logic                  reply_slow_en;
  logic [1:0]            reply_slow_reason;
  logic [BANK_WIDTH-1:0] reply_slow_idx;
  logic                  success;
  logic [BANK_WIDTH-1:0] success_idx;
  logic                  miss_full;

  // Pipeline / issue-queue side
  modport master (
    output issue_en, issue_idx, issue_rob_idx, issue_exception,
           s1_tlb_miss, s1_bank_conflict, s2_dcache_miss, s2_mshr_id,
           s2_mshr_full, s2_forward_fail, refill_en, refill_mshr_id,
           redirect, redirect_rob_idx,
    input  reply_fast_en, reply_fast_reason, reply_fast_idx,
           reply_slow_en, reply_slow_reason, reply_slow_idx,
           success, success_idx, miss_full
  );

  // Reply unit side
  modport slave (
    input  issue_en, issue_idx, issue_rob_idx, issue_exception,
           s1_tlb_miss, s1_bank_conflict, s2_dcache_miss, s2_mshr_id,
           s2_mshr_full, s2_forward_fail, refill_en, refill_mshr_id,
           redirect, redirect_rob_idx,
    output reply_fast_en, reply_fast_reason, reply_fast_idx,
           reply_slow_en, reply_slow_reason, reply_slow_idx,
           success, success_idx, miss_full
  );
endinterface

// File: rtl/load_reply_unit.sv
// Load-pipeline reply unit: tracks loads through S1/S2, produces issue-queue
// feedback and parks dcache misses until their refill wakes them.
module load_reply_unit #(
  parameter int BANK_WIDTH = 4,
  parameter int ROB_WIDTH  = 6,
  parameter int MISS_DEPTH = 4,
  parameter int MSHR_WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  load_reply_unit_if.slave bus
);
  localparam int RW = ROB_WIDTH + 1;

  logic                  s1_valid_q, s1_valid_d, s1_exc_q, s1_exc_d;
  logic [BANK_WIDTH-1:0] s1_idx_q, s1_idx_d;
  logic [RW-1:0]         s1_rob_q, s1_rob_d;
  logic                  s2_valid_q, s2_valid_d, s2_exc_q, s2_exc_d;
  logic [BANK_WIDTH-1:0] s2_idx_q, s2_idx_d;
  logic [RW-1:0]         s2_rob_q, s2_rob_d;

  logic [MISS_DEPTH-1:0]                 mb_valid_q, mb_valid_d, mb_ready_q, mb_ready_d;
  logic [MISS_DEPTH-1:0][MSHR_WIDTH-1:0] mb_mshr_q, mb_mshr_d;
  logic [MISS_DEPTH-1:0][BANK_WIDTH-1:0] mb_idx_q, mb_idx_d;
  logic [MISS_DEPTH-1:0][RW-1:0]         mb_rob_q, mb_rob_d;

  logic                  s1_live, s2_live, s2_slow, mb_alloc, found;
  logic [MISS_DEPTH-1:0] mb_kill, free_oh, wake_oh;

  // Entry survives a flush when it is older than the boundary; the dir bit
  // flips the sense of the index compare across a rob wrap.
  function automatic logic keep(input logic [RW-1:0] e, input logic [RW-1:0] r);
    return (e[RW-1] ^ r[RW-1]) ^ (r[RW-2:0] > e[RW-2:0]);
  endfunction

  // Stage liveness, fast replay and S1/S2 advance
  always_comb begin
    s1_live = s1_valid_q && !(bus.redirect && !keep(s1_rob_q, bus.redirect_rob_idx));
    s2_live = s2_valid_q && !(bus.redirect && !keep(s2_rob_q, bus.redirect_rob_idx));
    bus.reply_fast_en     = 1'b0;
    bus.reply_fast_reason = 2'b00;
    bus.reply_fast_idx    = '0;
    if (s1_live && !s1_exc_q) begin
      if (bus.s1_tlb_miss) begin
        bus.reply_fast_en     = 1'b1;
        bus.reply_fast_reason = 2'b11;
      end else if (bus.s1_bank_conflict) begin
        bus.reply_fast_en     = 1'b1;
        bus.reply_fast_reason = 2'b01;
      end
    end
    if (bus.reply_fast_en) bus.reply_fast_idx = s1_idx_q;
    // A replayed load is dropped here; the issue queue will re-issue it.
    s1_valid_d = bus.issue_en &&
                 !(bus.redirect && !keep(bus.issue_rob_idx, bus.redirect_rob_idx));
    s1_idx_d   = bus.issue_idx;
    s1_rob_d   = bus.issue_rob_idx;
    s1_exc_d   = bus.issue_exception;
    s2_valid_d = s1_live && !bus.reply_fast_en;
    s2_idx_d   = s1_idx_q;
    s2_rob_d   = s1_rob_q;
    s2_exc_d   = s1_exc_q;
  end

  // S2 outcome, miss-buffer wake arbitration and buffer next state
  always_comb begin
    bus.success       = 1'b0;
    bus.success_idx   = '0;
    bus.reply_slow_en = 1'b0;
    bus.reply_slow_reason = 2'b00;
    bus.reply_slow_idx    = '0;
    bus.miss_full     = &mb_valid_q;
    s2_slow  = 1'b0;
    mb_alloc = 1'b0;
    free_oh  = '0;
    wake_oh  = '0;
    for (int i = 0; i < MISS_DEPTH; i++)
      mb_kill[i] = mb_valid_q[i] && bus.redirect && !keep(mb_rob_q[i], bus.redirect_rob_idx);
    found = 1'b0;
    for (int i = 0; i < MISS_DEPTH; i++)
      if (!found && !mb_valid_q[i]) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
    if (s2_live) begin
      if (s2_exc_q) begin
        bus.success = 1'b1;
      end else if (bus.s2_forward_fail) begin
        s2_slow = 1'b1;
        bus.reply_slow_reason = 2'b01;
      end else if (bus.s2_dcache_miss && !bus.s2_mshr_full && (|free_oh)) begin
        mb_alloc = 1'b1;
      end else if (bus.s2_dcache_miss) begin
        s2_slow = 1'b1;
        bus.reply_slow_reason = 2'b10;
      end else begin
        bus.success = 1'b1;
      end
    end
    if (bus.success) bus.success_idx = s2_idx_q;
    if (s2_slow) begin
      bus.reply_slow_en  = 1'b1;
      bus.reply_slow_idx = s2_idx_q;
    end else begin
      found = 1'b0;
      for (int i = 0; i < MISS_DEPTH; i++)
        if (!found && mb_valid_q[i] && mb_ready_q[i] && !mb_kill[i]) begin
          wake_oh[i]            = 1'b1;
          found                 = 1'b1;
          bus.reply_slow_en     = 1'b1;
          bus.reply_slow_reason = 2'b11;
          bus.reply_slow_idx    = mb_idx_q[i];
        end
    end
    mb_valid_d = mb_valid_q;
    mb_ready_d = mb_ready_q;
    mb_mshr_d  = mb_mshr_q;
    mb_idx_d   = mb_idx_q;
    mb_rob_d   = mb_rob_q;
    for (int i = 0; i < MISS_DEPTH; i++) begin
      if (mb_kill[i] || wake_oh[i]) begin
        mb_valid_d[i] = 1'b0;
        mb_ready_d[i] = 1'b0;
      end else if (mb_valid_q[i] && bus.refill_en && mb_mshr_q[i] == bus.refill_mshr_id) begin
        mb_ready_d[i] = 1'b1;
      end
      // Refill racing the allocation is caught here so the wake is not lost.
      if (mb_alloc && free_oh[i]) begin
        mb_valid_d[i] = 1'b1;
        mb_ready_d[i] = bus.refill_en && (bus.refill_mshr_id == bus.s2_mshr_id);
        mb_mshr_d[i]  = bus.s2_mshr_id;
        mb_idx_d[i]   = s2_idx_q;
        mb_rob_d[i]   = s2_rob_q;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_exc_q   <= 1'b0;
      s1_idx_q   <= '0;
      s1_rob_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_exc_q   <= 1'b0;
      s2_idx_q   <= '0;
      s2_rob_q   <= '0;
      mb_valid_q <= '0;
      mb_ready_q <= '0;
      mb_mshr_q  <= '0;
      mb_idx_q   <= '0;
      mb_rob_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_exc_q   <= s1_exc_d;
      s1_idx_q   <= s1_idx_d;
      s1_rob_q   <= s1_rob_d;
      s2_valid_q <= s2_valid_d;
      s2_exc_q   <= s2_exc_d;
      s2_idx_q   <= s2_idx_d;
      s2_rob_q   <= s2_rob_d;
      mb_valid_q <= mb_valid_d;
      mb_ready_q <= mb_ready_d;
      mb_mshr_q  <= mb_mshr_d;
      mb_idx_q   <= mb_idx_d;
      mb_rob_q   <= mb_rob_d;
    end
  end
endmodule

// File: tb/tb_load_reply_unit.sv
// Directed bench for load_reply_unit: S1/S2 flow, replays, miss buffer,
// redirect kill and mid-run reset.
module tb_load_reply_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;

  load_reply_unit_if #(.BANK_WIDTH(4), .ROB_WIDTH(6), .MSHR_WIDTH(2)) bus ();

  load_reply_unit #(.BANK_WIDTH(4), .ROB_WIDTH(6), .MISS_DEPTH(4), .MSHR_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.issue_en = 0; bus.issue_idx = 0; bus.issue_rob_idx = 0; bus.issue_exception = 0;
    bus.s1_tlb_miss = 0; bus.s1_bank_conflict = 0;
    bus.s2_dcache_miss = 0; bus.s2_mshr_id = 0; bus.s2_mshr_full = 0; bus.s2_forward_fail = 0;
    bus.refill_en = 0; bus.refill_mshr_id = 0; bus.redirect = 0; bus.redirect_rob_idx = 0;
  endtask

  // advance one clock; inputs return to idle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic issue(input logic [3:0] idx, input logic [6:0] rob);
    bus.issue_en = 1; bus.issue_idx = idx; bus.issue_rob_idx = rob;
  endtask

  // issue a load that misses in S2 and is parked with the given mshr
  task automatic miss_load(input logic [3:0] idx, input logic [6:0] rob, input logic [1:0] mshr);
    issue(idx, rob);
    tick();
    tick();
    bus.s2_dcache_miss = 1; bus.s2_mshr_id = mshr;
    #1;
    chk("alloc_no_slow", 32'(bus.reply_slow_en), 0);
    tick();
  endtask

  initial begin
    idle();
    #2;
    chk("rst_fast", 32'(bus.reply_fast_en), 0);
    chk("rst_slow", 32'(bus.reply_slow_en), 0);
    chk("rst_success", 32'(bus.success), 0);
    chk("rst_full", 32'(bus.miss_full), 0);
    #1 rst = 1;
    tick();

    // plain hit: success two cycles after issue
    issue(4'd5, 7'h01);
    tick();
    #1;
    chk("s1_no_fast", 32'(bus.reply_fast_en), 0);
    chk("s1_no_success", 32'(bus.success), 0);
    tick();
    #1;
    chk("hit_success", 32'(bus.success), 1);
    chk("hit_success_idx", 32'(bus.success_idx), 5);
    chk("hit_no_slow", 32'(bus.reply_slow_en), 0);
    tick();

    // tlb miss beats bank conflict; load does not reach S2
    issue(4'd3, 7'h02);
    tick();
    bus.s1_tlb_miss = 1; bus.s1_bank_conflict = 1;
    #1;
    chk("fast_en", 32'(bus.reply_fast_en), 1);
    chk("fast_reason", 32'(bus.reply_fast_reason), 3);
    chk("fast_idx", 32'(bus.reply_fast_idx), 3);
    tick();
    #1;
    chk("fast_no_s2", 32'(bus.success), 0);
    tick();

    // bank conflict alone
    issue(4'd4, 7'h02);
    tick();
    bus.s1_bank_conflict = 1;
    #1;
    chk("bank_reason", 32'(bus.reply_fast_reason), 1);
    tick();

    // single miss and refill wake
    miss_load(4'd7, 7'h03, 2'd2);
    #1;
    chk("miss_quiet", 32'(bus.reply_slow_en), 0);
    tick();
    bus.refill_en = 1; bus.refill_mshr_id = 2'd2;
    #1;
    chk("refill_cycle_quiet", 32'(bus.reply_slow_en), 0);
    tick();
    #1;
    chk("wake_en", 32'(bus.reply_slow_en), 1);
    chk("wake_reason", 32'(bus.reply_slow_reason), 3);
    chk("wake_idx", 32'(bus.reply_slow_idx), 7);
    tick();
    #1;
    chk("wake_freed", 32'(bus.reply_slow_en), 0);
    chk("wake_not_full", 32'(bus.miss_full), 0);

    // fill buffer, fifth miss gets no-resource replay
    for (int i = 0; i < 4; i++) miss_load(4'(8 + i), 7'(4 + i), 2'd1);
    #1;
    chk("full", 32'(bus.miss_full), 1);
    issue(4'd12, 7'h08);
    tick();
    tick();
    bus.s2_dcache_miss = 1; bus.s2_mshr_id = 2'd3;
    #1;
    chk("nores_en", 32'(bus.reply_slow_en), 1);
    chk("nores_reason", 32'(bus.reply_slow_reason), 2);
    chk("nores_idx", 32'(bus.reply_slow_idx), 12);
    tick();

    // forward fail in S2 pre-empts a ready wake
    issue(4'd13, 7'h09);
    tick();
    bus.refill_en = 1; bus.refill_mshr_id = 2'd1;
    #1;
    chk("pre_ready_quiet", 32'(bus.reply_slow_en), 0);
    tick();
    bus.s2_forward_fail = 1;
    #1;
    chk("ff_reason", 32'(bus.reply_slow_reason), 1);
    chk("ff_idx", 32'(bus.reply_slow_idx), 13);
    tick();
    #1;
    chk("retry_reason", 32'(bus.reply_slow_reason), 3);
    chk("retry_idx", 32'(bus.reply_slow_idx), 8);
    chk("full_until_edge", 32'(bus.miss_full), 1);
    tick();
    #1;
    chk("wake2_idx", 32'(bus.reply_slow_idx), 9);
    chk("full_cleared", 32'(bus.miss_full), 0);
    tick();
    #1;
    chk("wake3_idx", 32'(bus.reply_slow_idx), 10);
    tick();
    #1;
    chk("wake4_idx", 32'(bus.reply_slow_idx), 11);
    tick();
    #1;
    chk("drained", 32'(bus.reply_slow_en), 0);

    // redirect with boundary {0,4}
    miss_load(4'd1, 7'h41, 2'd3);
    miss_load(4'd2, 7'h03, 2'd3);
    issue(4'd4, 7'h02);
    tick();
    issue(4'd6, 7'h06);
    tick();
    bus.redirect = 1; bus.redirect_rob_idx = 7'h04; bus.s1_tlb_miss = 1;
    #1;
    chk("redir_s2_success", 32'(bus.success), 1);
    chk("redir_s2_idx", 32'(bus.success_idx), 4);
    chk("redir_s1_killed", 32'(bus.reply_fast_en), 0);
    tick();
    #1;
    chk("redir_s2_empty", 32'(bus.success), 0);
    bus.refill_en = 1; bus.refill_mshr_id = 2'd3;
    #1;
    chk("redir_refill_quiet", 32'(bus.reply_slow_en), 0);
    tick();
    #1;
    chk("survivor_wake", 32'(bus.reply_slow_en), 1);
    chk("survivor_idx", 32'(bus.reply_slow_idx), 2);
    tick();
    #1;
    chk("killed_no_wake", 32'(bus.reply_slow_en), 0);

    // mid-run reset with full buffer
    for (int i = 0; i < 4; i++) miss_load(4'(i), 7'(i), 2'd0);
    #1;
    chk("full2", 32'(bus.miss_full), 1);
    rst = 0;
    #1;
    chk("mrst_full", 32'(bus.miss_full), 0);
    chk("mrst_slow", 32'(bus.reply_slow_en), 0);
    chk("mrst_success", 32'(bus.success), 0);
    chk("mrst_fast", 32'(bus.reply_fast_en), 0);
    #1 rst = 1;
    tick();
    bus.refill_en = 1; bus.refill_mshr_id = 2'd0;
    tick();
    #1;
    chk("post_rst_no_wake", 32'(bus.reply_slow_en), 0);
    chk("post_rst_empty", 32'(bus.miss_full), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
